logic16_arbiter: RTL

- Round-robin arbiter and sequencer sharing one 16-bit bitwise logic unit (OR/AND/XOR/NOT) among N_REQ requesters.
- Each requester issues an operand pair and an opcode over a valid/ready handshake and receives a registered result over a valid/ready response handshake.
- Sits between the CPU-side request sources and the single combinational logic datapath.
- Serialises access so only one 16-bit logic unit is instantiated.

---
 rtl/logic16_arbiter_pkg.sv | 19 +
 rtl/logic16_unit.sv | 29 ++
 rtl/logic16_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/logic16_arbiter_pkg.sv
// Shared opcode and FSM state encodings for the logic16 arbiter slice.
package logic16_arbiter_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/logic16_unit.sv
// Combinational bitwise logic unit: per-bit gate array followed by a 4:1 select.
module logic16_unit
    import logic16_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  op_e              op,
    input  logic [0:WIDTH-1] in0,
    input  logic [0:WIDTH-1] in1,
    output logic [0:WIDTH-1] result
);

    logic [0:WIDTH-1] or_v;
    logic [0:WIDTH-1] and_v;
    logic [0:WIDTH-1] xor_v;
    logic [0:WIDTH-1] not_v;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        or  u_or  (or_v[i],  in0[i], in1[i]);
        and u_and (and_v[i], in0[i], in1[i]);
        xor u_xor (xor_v[i], in0[i], in1[i]);
        not u_not (not_v[i], in0[i]);

        // op[1] picks the XOR/NOT pair, op[0] the odd member of each pair
        assign result[i] = op[1] ? (op[0] ? not_v[i] : xor_v[i])
                                 : (op[0] ? and_v[i] : or_v[i]);
    end

endmodule

// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sequencing N_REQ requesters onto one shared logic16_unit.
module logic16_arbiter
    import logic16_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [0:2*N_REQ-1]       req_op,
    input  logic [0:WIDTH*N_REQ-1]   req_in0,
    input  logic [0:WIDTH*N_REQ-1]   req_in1,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic [0:WIDTH-1]         rsp_data,
    output logic                     busy
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state;
    logic [PTR_W-1:0]   rr;
    logic [PTR_W-1:0]   owner;
    op_e                op_q;
    logic [0:WIDTH-1]   in0_q;
    logic [0:WIDTH-1]   in1_q;
    logic [0:WIDTH-1]   unit_result;

    op_e                op_arr  [N_REQ];
    logic [0:WIDTH-1]   in0_arr [N_REQ];
    logic [0:WIDTH-1]   in1_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign op_arr[i]  = op_e'(req_op[2*i +: 2]);
        assign in0_arr[i] = req_in0[WIDTH*i +: WIDTH];
        assign in1_arr[i] = req_in1[WIDTH*i +: WIDTH];
    end

    // First valid requester at or after the rr pointer, wrapping past N_REQ-1
    logic [PTR_W-1:0] grant;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((32'(rr) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    logic [N_REQ-1:0] grant_oh;
    logic [N_REQ-1:0] owner_oh;
    logic [PTR_W-1:0] next_rr;

    assign grant_oh  = N_REQ'(1) << grant;
    assign owner_oh  = N_REQ'(1) << owner;
    assign next_rr   = (grant == PTR_W'(N_REQ - 1)) ? '0 : grant + PTR_W'(1);
    assign req_ready = (!rst && state == S_IDLE && found) ? grant_oh : '0;

    logic16_unit #(.WIDTH(WIDTH)) u_unit (
        .op     (op_q),
        .in0    (in0_q),
        .in1    (in1_q),
        .result (unit_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rr        <= '0;
            owner     <= '0;
            op_q      <= OP_OR;
            in0_q     <= '0;
            in1_q     <= '0;
            rsp_data  <= '0;
            rsp_valid <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        op_q  <= op_arr[grant];
                        in0_q <= in0_arr[grant];
                        in1_q <= in1_arr[grant];
                        owner <= grant;
                        rr    <= next_rr;
                        busy  <= 1'b1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_data  <= unit_result;
                    rsp_valid <= owner_oh;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    // only the owner's rsp_ready completes the response
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
